// File: rtl/scandoubler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common (package)
//  Description : Shared constants, pixel type and colour helper for the
//                scandoubler slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package common;

    localparam int SD_LINE_BITS    = 9;
    localparam int SD_LINE_DEFAULT = 448;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } rgb18_t;

    // Halve every colour channel (scanline dimming)
    function automatic rgb18_t rgb_half(input rgb18_t c);
        rgb18_t h;
        h.r = c.r >> 1;
        h.g = c.g >> 1;
        h.b = c.b >> 1;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scandoubler_if.sv
`default_nettype none
// ============================================================================
//  Module      : scandoubler_if
//  Description : 15 kHz video in / 31 kHz video out bundle. The slave modport
//                is the scandoubler, the master modport is the video source
//                and display sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scandoubler_if;
    logic [5:0] in_r;
    logic [5:0] in_g;
    logic [5:0] in_b;
    logic       in_hsync;
    logic       in_vsync;
    logic [5:0] out_r;
    logic [5:0] out_g;
    logic [5:0] out_b;
    logic       out_hsync;
    logic       out_vsync;

    modport master (
        output in_r, in_g, in_b, in_hsync, in_vsync,
        input  out_r, out_g, out_b, out_hsync, out_vsync
    );

    modport slave (
        input  in_r, in_g, in_b, in_hsync, in_vsync,
        output out_r, out_g, out_b, out_hsync, out_vsync
    );
endinterface
`default_nettype wire

// File: rtl/scandoubler_linebuf.sv
`default_nettype none
// ============================================================================
//  Module      : scandoubler_linebuf
//  Description : Simple dual-port line RAM, 1024 x 18 (two 512-entry banks),
//                one write port, one read port with registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module scandoubler_linebuf (
    input  wire         clk,
    input  wire         i_we,
    input  wire  [9:0]  i_waddr,
    input  wire  [17:0] i_wdata,
    input  wire  [9:0]  i_raddr,
    output logic [17:0] o_rdata
);
    logic [17:0] mem [0:1023];
    logic [17:0] rdata_q;

    // Write port and registered read port; contents are never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        rdata_q <= mem[i_raddr];
    end

    assign o_rdata = rdata_q;
endmodule
`default_nettype wire

// File: rtl/scandoubler.sv
`default_nettype none
// ============================================================================
//  Module      : scandoubler
//  Description : 15 kHz to 31 kHz line doubler. Input lines are written into
//                one line-buffer bank at the ck7 rate while the other bank is
//                read twice at the ck14 rate. Output hsync is regenerated from
//                the read address; syncs and phase are pipelined to match the
//                two-clock RAM + output register data path.
//                Optional feature macro: SCANDOUBLER_SCANLINES_EN (adds the
//                scanlines port and dims every second output line).
//  Revision    : 1.0 - initial release
// ============================================================================
module scandoubler
    import common::*;
#(
    parameter int HSYNC_WIDTH  = 54,
    parameter int LINE_DEFAULT = SD_LINE_DEFAULT
) (
    input  wire          clk28,
    input  wire          rst,
    input  wire          ck7,
    input  wire          ck14,
`ifdef SCANDOUBLER_SCANLINES_EN
    input  wire          scanlines,
`endif
    scandoubler_if.slave vid
);
    typedef logic [SD_LINE_BITS-1:0] addr_t;
    typedef logic [SD_LINE_BITS:0]   len_t;

    localparam len_t  c_hs_width    = len_t'(HSYNC_WIDTH);
    localparam len_t  c_min_len     = len_t'(2 * HSYNC_WIDTH);
    localparam len_t  c_len_default = len_t'(LINE_DEFAULT);
    localparam addr_t c_addr_last   = '1;

    // Line control state
    logic  hs_in_q,   hs_in_d;
    logic  wb_q,      wb_d;
    addr_t wr_addr_q, wr_addr_d;
    logic  wr_full_q, wr_full_d;
    len_t  line_len_q, line_len_d;
    addr_t rd_addr_q, rd_addr_d;
    logic  phase_q,   phase_d;

    // Output pipeline (stage 1 runs alongside the RAM read)
    logic   hs_p1_q, hs_p1_d;
    logic   vs_p1_q, vs_p1_d;
    logic   ph_p1_q, ph_p1_d;
    rgb18_t out_rgb_q, out_rgb_d;
    logic   out_hsync_q, out_hsync_d;
    logic   out_vsync_q, out_vsync_d;

    logic   hs_fall;
    logic   wr_en;
    len_t   wr_len;
    rgb18_t ram_rdata;
    rgb18_t pix;

    scandoubler_linebuf u_linebuf (
        .clk     (clk28),
        .i_we    (wr_en & ~rst),
        .i_waddr ({wb_q, wr_addr_q}),
        .i_wdata ({vid.in_r, vid.in_g, vid.in_b}),
        .i_raddr ({~wb_q, rd_addr_q}),
        .o_rdata (ram_rdata)
    );

    // Next-state for write/read counters; an hsync fall overrides a read wrap
    always_comb begin
        hs_fall    = ck7 & hs_in_q & ~vid.in_hsync;
        wr_en      = ck7 & ~wr_full_q;
        wr_len     = {1'b0, wr_addr_q} + len_t'(1);
        hs_in_d    = ck7 ? vid.in_hsync : hs_in_q;
        wb_d       = wb_q;
        wr_addr_d  = wr_addr_q;
        wr_full_d  = wr_full_q;
        line_len_d = line_len_q;
        rd_addr_d  = rd_addr_q;
        phase_d    = phase_q;

        if (wr_en) begin
            if (wr_addr_q == c_addr_last) begin
                wr_full_d = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + addr_t'(1);
            end
        end

        if (ck14) begin
            if ({1'b0, rd_addr_q} == line_len_q - len_t'(1)) begin
                rd_addr_d = '0;
                phase_d   = ~phase_q;
            end else begin
                rd_addr_d = rd_addr_q + addr_t'(1);
            end
        end

        if (hs_fall) begin
            wb_d      = ~wb_q;
            wr_addr_d = '0;
            wr_full_d = 1'b0;
            rd_addr_d = '0;
            phase_d   = 1'b0;
            // Too-short lines are sync glitches: keep the previous length
            if (wr_len >= c_min_len) begin
                line_len_d = wr_len;
            end
        end
    end

    // Output pipeline: sync regeneration, vsync line alignment, blanking, dimming
    always_comb begin
        hs_p1_d = ({1'b0, rd_addr_q} >= c_hs_width);
        vs_p1_d = (rd_addr_q == '0) ? vid.in_vsync : vs_p1_q;
        ph_p1_d = phase_q;

        pix = ram_rdata;
`ifdef SCANDOUBLER_SCANLINES_EN
        if (scanlines && ph_p1_q) begin
            pix = rgb_half(ram_rdata);
        end
`endif
        out_rgb_d   = hs_p1_q ? pix : '0;
        out_hsync_d = hs_p1_q;
        out_vsync_d = vs_p1_q;
    end

    // Control registers
    always_ff @(posedge clk28) begin
        if (rst) begin
            hs_in_q    <= 1'b1;
            wb_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_full_q  <= 1'b0;
            line_len_q <= c_len_default;
            rd_addr_q  <= '0;
            phase_q    <= 1'b0;
        end else begin
            hs_in_q    <= hs_in_d;
            wb_q       <= wb_d;
            wr_addr_q  <= wr_addr_d;
            wr_full_q  <= wr_full_d;
            line_len_q <= line_len_d;
            rd_addr_q  <= rd_addr_d;
            phase_q    <= phase_d;
        end
    end

    // Pipeline and output registers
    always_ff @(posedge clk28) begin
        if (rst) begin
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
            ph_p1_q     <= 1'b0;
            out_rgb_q   <= '0;
            out_hsync_q <= 1'b1;
            out_vsync_q <= 1'b1;
        end else begin
            hs_p1_q     <= hs_p1_d;
            vs_p1_q     <= vs_p1_d;
            ph_p1_q     <= ph_p1_d;
            out_rgb_q   <= out_rgb_d;
            out_hsync_q <= out_hsync_d;
            out_vsync_q <= out_vsync_d;
        end
    end

    assign vid.out_r     = out_rgb_q.r;
    assign vid.out_g     = out_rgb_q.g;
    assign vid.out_b     = out_rgb_q.b;
    assign vid.out_hsync = out_hsync_q;
    assign vid.out_vsync = out_vsync_q;
endmodule
`default_nettype wire

// File: tb/tb_scandoubler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_scandoubler
//  Description : Self-checking bench for scandoubler. Drives 15 kHz lines of
//                several lengths with ramp / random / constant pixels and
//                compares every output cycle with a line-level model.
//                Honours SCANDOUBLER_SCANLINES_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scandoubler;
    localparam int HW    = 54;
    localparam int HS_PX = 33;

    logic clk28 = 1'b0;
    logic rst   = 1'b1;
    logic ck7   = 1'b0;
    logic ck14  = 1'b0;
`ifdef SCANDOUBLER_SCANLINES_EN
    logic scanlines = 1'b0;
`endif

    scandoubler_if vid ();

    scandoubler #(.HSYNC_WIDTH(HW), .LINE_DEFAULT(448)) dut (
        .clk28 (clk28),
        .rst   (rst),
        .ck7   (ck7),
        .ck14  (ck14),
`ifdef SCANDOUBLER_SCANLINES_EN
        .scanlines (scanlines),
`endif
        .vid   (vid)
    );

    always #18 clk28 = ~clk28;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mem_m [2][512];
    bit known [2][512];
    int m_hs_prev = 1, m_wb = 0, m_wr = 0, m_full = 0, m_len = 448;
    int m_rd = 0, m_ph = 0, m_vs1 = 1;
    // value computed one edge earlier (what the RAM stage holds)
    int s_rgb = -1, s_hs = 1, s_vs = 1, s_ph = 0;
    int e_rgb, e_hs, e_vs;
    bit meas_en = 0;
    int exp_period = 896;
    int cyc = 0, last_fall = -1, prev_ohs = 1;

    function automatic int half_rgb(input int v);
        int r, g, b;
        r = (v / 4096) % 64;
        g = (v / 64) % 64;
        b = v % 64;
        return ((r / 2) * 4096) + ((g / 2) * 64) + (b / 2);
    endfunction

    always @(posedge clk28) begin
        int n_rgb, n_hs, n_vs, pix;
        bit fall, sl;
`ifdef SCANDOUBLER_SCANLINES_EN
        sl = scanlines;
`else
        sl = 1'b0;
`endif
        if (rst) begin
            e_rgb = 0; e_hs = 1; e_vs = 1;
            s_rgb = -1; s_hs = 1; s_vs = 1; s_ph = 0;
            m_hs_prev = 1; m_wb = 0; m_wr = 0; m_full = 0; m_len = 448;
            m_rd = 0; m_ph = 0; m_vs1 = 1;
        end else begin
            // what is read this edge shows up at the pins one edge later
            n_rgb = known[1 - m_wb][m_rd] ? mem_m[1 - m_wb][m_rd] : -1;
            n_hs  = (m_rd >= HW) ? 1 : 0;
            n_vs  = (m_rd == 0) ? int'(vid.in_vsync) : m_vs1;
            m_vs1 = n_vs;

            e_hs = s_hs;
            e_vs = s_vs;
            if (s_hs == 0)                  e_rgb = 0;
            else if (s_rgb < 0)             e_rgb = -1;
            else if (sl && (s_ph == 1))     e_rgb = half_rgb(s_rgb);
            else                            e_rgb = s_rgb;
            s_rgb = n_rgb; s_hs = n_hs; s_vs = n_vs; s_ph = m_ph;

            pix  = int'({vid.in_r, vid.in_g, vid.in_b});
            fall = ck7 && (m_hs_prev == 1) && !vid.in_hsync;
            if (ck7) m_hs_prev = int'(vid.in_hsync);
            if (ck7 && m_full == 0) begin
                mem_m[m_wb][m_wr] = pix;
                known[m_wb][m_wr] = 1'b1;
            end
            if (fall) begin
                if (m_wr + 1 >= 2 * HW) m_len = m_wr + 1;
                m_wb = 1 - m_wb; m_wr = 0; m_full = 0; m_rd = 0; m_ph = 0;
            end else begin
                if (ck7 && m_full == 0) begin
                    if (m_wr == 511) m_full = 1;
                    else             m_wr++;
                end
                if (ck14) begin
                    m_rd++;
                    if (m_rd >= m_len) begin
                        m_rd = 0;
                        m_ph = 1 - m_ph;
                    end
                end
            end
        end

        #1;
        check_value("out_hsync", int'(vid.out_hsync), e_hs);
        check_value("out_vsync", int'(vid.out_vsync), e_vs);
        if (e_rgb >= 0) check_value("out_rgb", int'({vid.out_r, vid.out_g, vid.out_b}), e_rgb);

        // independent period / pulse-width measurement in steady stretches
        if (!meas_en) begin
            last_fall = -1;
        end else begin
            if (prev_ohs == 1 && !vid.out_hsync) begin
                if (last_fall >= 0) check_value("hs_period", cyc - last_fall, exp_period);
                last_fall = cyc;
            end
            if (prev_ohs == 0 && vid.out_hsync && last_fall >= 0)
                check_value("hs_low", cyc - last_fall, 2 * HW);
        end
        prev_ohs = int'(vid.out_hsync);
        cyc++;
    end

    // ---------------- stimulus ----------------
    // mode 0: ramp (pixel index), 1: random, 2: all channels 3F
    task automatic drive_line(input int npx, input int mode, input int vs_px, input int rst_px);
        for (int p = 0; p < npx; p++) begin
            logic [17:0] pix;
            case (mode)
                0:       pix = 18'(p);
                1:       pix = 18'($urandom);
                default: pix = 18'h3FFFF;
            endcase
            if (p < HS_PX) pix = '0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk28);
                ck7  = (c == 0);
                ck14 = (c % 2 == 0);
                vid.in_hsync = (p >= HS_PX);
                {vid.in_r, vid.in_g, vid.in_b} = pix;
                if (p == vs_px && c == 1) vid.in_vsync = ~vid.in_vsync;
                rst = (p == rst_px && c == 1);
            end
        end
    endtask

    initial begin
        vid.in_r = '0; vid.in_g = '0; vid.in_b = '0;
        vid.in_hsync = 1'b1; vid.in_vsync = 1'b1;
        repeat (6) @(negedge clk28);
        rst = 1'b0;

        // 448-pixel ramp lines, then random lines with vsync moving mid-line
        repeat (3) drive_line(448, 0, -1, -1);
        exp_period = 896; meas_en = 1;
        repeat (3) drive_line(448, 0, -1, -1);
        repeat (4) drive_line(448, 1, $urandom_range(40, 400), -1);

        // switch to 456-pixel lines
        meas_en = 0;
        repeat (3) drive_line(456, 1, -1, -1);
        exp_period = 912; meas_en = 1;
        repeat (2) drive_line(456, 1, -1, -1);

        // 40-pixel glitch line between normal lines
        meas_en = 0;
        repeat (2) drive_line(448, 1, -1, -1);
        drive_line(40, 1, -1, -1);
        repeat (2) drive_line(448, 1, -1, -1);
        exp_period = 896; meas_en = 1;
        repeat (2) drive_line(448, 1, -1, -1);

        // reset pulsed mid-line
        meas_en = 0;
        drive_line(448, 1, -1, 200);
        repeat (3) drive_line(448, 1, -1, -1);
        meas_en = 1;
        repeat (2) drive_line(448, 0, -1, -1);

        // over-long line saturates the write address
        meas_en = 0;
        drive_line(530, 0, -1, -1);
        repeat (3) drive_line(448, 1, -1, -1);

`ifdef SCANDOUBLER_SCANLINES_EN
        scanlines = 1'b1;
        repeat (3) drive_line(448, 2, -1, -1);
        scanlines = 1'b0;
        repeat (2) drive_line(448, 2, -1, -1);
`endif
        repeat (8) @(negedge clk28);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/scandoubler.md
SCANDOUBLER -- requirements
Module: scandoubler

Interface
REQ-001 Parameter HSYNC_WIDTH, default 54: output hsync pulse length, in output (14 MHz) pixels.
REQ-002 Parameter LINE_DEFAULT, default 448: line length, in input pixels, used until the first line is measured.
REQ-003 clk28  input  1  28 MHz system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ck7  input  1  input pixel enable; one clk28 pulse per 4 clocks.
REQ-006 ck14  input  1  output pixel enable; one clk28 pulse per 2 clocks, coincident with ck7 when ck7 is high.
REQ-007 in_r/in_g/in_b  input  6 each  15 kHz RGB, already blanked.
REQ-008 in_hsync, in_vsync  input  1 each  15 kHz syncs, active low.
REQ-009 scanlines  input  1  scanline dimming enable; exists only with SCANDOUBLER_SCANLINES_EN.
REQ-010 out_r/out_g/out_b  output  6 each  31 kHz RGB.
REQ-011 out_hsync, out_vsync  output  1 each  31 kHz syncs, active low.

Function
REQ-012 in_hsync SHALL be registered on ck7; a fall is a 1-to-0 change between successive ck7 samples.
REQ-013 Line buffer: 2 banks of 512 x 18 bits. Write bank wb toggles on each in_hsync fall; read bank is ~wb.
REQ-014 Write path:
- Each ck7 writes {in_r,in_g,in_b} to bank wb at wr_addr (9 bit), then wr_addr increments.
- wr_addr saturates at 511; writes beyond that are dropped.
- On in_hsync fall, wr_addr<=0 and line_len<=wr_addr+1, capped at 512.
REQ-015 Read path:
- rd_addr advances on each ck14.
- It wraps to 0 after line_len-1, giving two output lines per input line.
- On in_hsync fall, rd_addr<=0 and phase<=0 (resync).
- phase toggles on each rd_addr wrap.
REQ-016 If a wrap and an in_hsync fall occur in the same cycle, the hsync fall SHALL take priority.
REQ-017 RAM read latency is 1 clk28; output registers add 1 clk28.
REQ-018 Syncs and phase SHALL be delayed to match the data path, so total rd_addr-to-pin latency is 2 clk28 for all outputs.
REQ-019 out_hsync SHALL be 0 for rd_addr in [0, HSYNC_WIDTH), otherwise 1.
REQ-020 While out_hsync is 0, RGB SHALL be forced to 0.
REQ-021 out_vsync SHALL resample in_vsync only at rd_addr==0, so vsync edges align to output line starts.
REQ-022 If line_len < 2*HSYNC_WIDTH, the previous line_len SHALL be kept (glitch rejection).

Reset
REQ-023 While rst is high, SHALL hold:
- wr_addr=0, rd_addr=0, wb=0, phase=0, line_len=LINE_DEFAULT
- out_r/out_g/out_b=0, out_hsync=1, out_vsync=1
REQ-024 Line buffer contents are not reset.
REQ-025 Reset asserted mid-line SHALL take effect on the next clk28 edge, with no partial-state carryover.

Configuration
REQ-026 With SCANDOUBLER_SCANLINES_EN defined: the scanlines port exists. When scanlines=1 and phase=1, each output colour SHALL be the stored value shifted right 1 bit.
REQ-027 Without SCANDOUBLER_SCANLINES_EN: the scanlines port and the dimming logic are absent; output always equals the stored value.

Structure
REQ-028 Package common SHALL hold the constants SD_LINE_BITS=9 and SD_LINE_DEFAULT=448, and the packed typedef rgb18_t {r,g,b}.
REQ-029 Sub-module scandoubler_linebuf: simple dual-port RAM, 1024 x 18, registered read, inferable as block RAM. No other sub-modules.

Verification
REQ-030 Input lines of 448 pixels (4.7 us hsync) -> out_hsync period 896 clk28 (~31.25 kHz), low for 108 clk28.
REQ-031 Line N filled with ramp value = pixel index -> lines N+1 and N+2 output the same ramp at 2x rate; pixel k appears k*2+2 clk28 after rd_addr=0.
REQ-032 Switch to 456-pixel lines -> line_len=456 after one line; outputs 912-clk28 lines with no more than one resync glitch.
REQ-033 in_hsync pulse producing a 40-pixel line -> line_len stays 448; output hsync period unchanged.
REQ-034 scanlines=1, input colour 6'h3F -> phase 0 line outputs 3F, phase 1 line outputs 1F; scanlines=0 -> both 3F.
REQ-035 rst pulsed mid-line -> next cycle outputs 0/1/1, line_len=448; normal output resumes within 2 input lines.
